// File: rtl/fdiv_monitor.sv
// Period and duty-cycle monitor for a divided clock sampled in the clk_in domain.
// Measures high/low phase lengths, checks against n_exp, tracks lock and stall.
module fdiv_monitor #(
    parameter int CW       = 16,
    parameter int LOCK_CNT = 3,
    parameter int TIMEOUT  = 1024
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          div_clk,
    input  logic [7:0]    n_exp,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_len,
    output logic          meas_valid,
    output logic          duty_ok,
    output logic          match,
    output logic          locked,
    output logic          stuck
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_MAX   = LW'(LOCK_CNT);

    typedef enum logic [1:0] {WAIT_RISE, HIGH, LOW} state_t;

    state_t        state;
    logic          s1, s2;
    logic [CW-1:0] hcnt, lcnt, idle_cnt;
    logic [LW-1:0] lock_cnt, lock_next;
    logic [7:0]    n_reg;

    logic          rise, fall, n_change, timeout_hit, publish;
    logic [CW:0]   sum;
    logic [CW-1:0] meas_period, diff;
    logic          meas_duty, meas_match;

    always_comb begin
        rise        = s1 & ~s2;
        fall        = ~s1 & s2;
        n_change    = (n_exp != n_reg);
        timeout_hit = !(rise || fall) && (idle_cnt == TIMEOUT_M1);
        publish     = (state == LOW) && rise && !n_change;

        sum         = {1'b0, hcnt} + {1'b0, lcnt};
        meas_period = sum[CW] ? CNT_MAX : sum[CW-1:0];
        diff        = (hcnt >= lcnt) ? (hcnt - lcnt) : (lcnt - hcnt);
        meas_duty   = (diff <= CNT_ONE);
        // Ratios below 2 cannot be meaningfully checked, so they never match.
        meas_match  = (n_reg >= 8'd2) && (meas_period == CW'(n_reg));

        lock_next = lock_cnt;
        if (n_change || timeout_hit) begin
            lock_next = '0;
        end else if (publish) begin
            if (!meas_match) begin
                lock_next = '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_next = lock_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= WAIT_RISE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            hcnt       <= '0;
            lcnt       <= '0;
            idle_cnt   <= '0;
            lock_cnt   <= '0;
            n_reg      <= n_exp;
            period     <= '0;
            high_len   <= '0;
            meas_valid <= 1'b0;
            duty_ok    <= 1'b0;
            match      <= 1'b0;
            locked     <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            s1         <= div_clk;
            s2         <= s1;
            n_reg      <= n_exp;
            meas_valid <= publish;
            lock_cnt   <= lock_next;
            locked     <= (lock_next == LOCK_MAX);

            if (rise || fall) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CNT_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout_hit) begin
                stuck <= 1'b1;
            end else if (rise) begin
                stuck <= 1'b0;
            end

            if (publish) begin
                period   <= meas_period;
                high_len <= hcnt;
                duty_ok  <= meas_duty;
                match    <= meas_match;
            end

            // A ratio change or a stall abandons the period in progress.
            if (n_change || timeout_hit) begin
                state <= WAIT_RISE;
            end else begin
                case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            hcnt  <= CNT_ONE;
                            state <= HIGH;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            lcnt  <= CNT_ONE;
                            state <= LOW;
                        end else if (s1 && hcnt != CNT_MAX) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            hcnt  <= CNT_ONE;
                            state <= HIGH;
                        end else if (!s1 && lcnt != CNT_MAX) begin
                            lcnt <= lcnt + 1'b1;
                        end
                    end
                    default: state <= WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: doc/fdiv_monitor.md
# fdiv_monitor

Period and duty-cycle monitor for the output of the programmable clock divider. It samples the divided clock in the `clk_in` domain and measures the high and low phase lengths in `clk_in` cycles. It checks the measured period against the expected divide ratio and asserts a lock flag after a run of consecutive matching periods. It sits directly downstream of the divider and is the self-check consumer of `clk_out`; it also detects a stalled divider.

## Interface
- `CW`, 16: width of the phase and period counters.
- `LOCK_CNT`, 3: number of consecutive matching periods required before `locked` asserts (1..15).
- `TIMEOUT`, 1024: number of `clk_in` cycles without a `div_clk` edge before `stuck` asserts. Must be less than 2^CW.

- `clk_in`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_clk`  in  1  divided clock from the divider, treated as data.
- `n_exp`  in  8  expected period in `clk_in` cycles (the divider's `n`).
- `period`  out  CW  last measured period: `high_len` + low length.
- `high_len`  out  CW  last measured high-phase length.
- `meas_valid`  out  1  one-cycle pulse when `period`, `high_len`, `duty_ok` and `match` update.
- `duty_ok`  out  1  |high − low| ≤ 1 for the last period.
- `match`  out  1  last period equals `n_exp`; qualified by `meas_valid`.
- `locked`  out  1  `LOCK_CNT` consecutive matches with `n_exp` stable.
- `stuck`  out  1  no `div_clk` edge within `TIMEOUT` cycles.

## Operation
- **Sampling.** `s1` ← `div_clk` and `s2` ← `s1` each cycle. `rise` = `s1 & ~s2`; `fall` = `~s1 & s2`. No other path from `div_clk`.
- **FSM states:** WAIT_RISE, HIGH, LOW.
  - WAIT_RISE: on `rise`, set `hcnt`=1 and go to HIGH.
  - HIGH: `hcnt`++ while `s1`=1. On `fall`, set `lcnt`=1 and go to LOW.
  - LOW: `lcnt`++ while `s1`=0. On `rise`, publish results, set `hcnt`=1 and go to HIGH.
- **Publish** (registered):
  - `high_len`←`hcnt`, `period`←`hcnt`+`lcnt`.
  - `duty_ok`←(|`hcnt`−`lcnt`| ≤ 1).
  - `match`←(`period` == zero-extended `n_exp`).
  - `meas_valid`=1 for one cycle.
- **Counters** saturate at 2^CW−1 and never wrap.
- **Lock counter.** Increments on a published match and saturates at `LOCK_CNT`; cleared to 0 by a published mismatch. `locked` = (lock counter == `LOCK_CNT`).
- **n_exp change.** `n_exp` is registered internally. A change in any cycle does all of the following on the next edge:
  - clears the lock counter and `locked`;
  - forces WAIT_RISE;
  - discards the partial period, so no `meas_valid` is issued for it.
- **n_exp < 2.** Comparison is disabled: `match`=0, `locked` held 0. Measurements still publish.
- **Timeout.**
  - An idle counter clears on every `rise`/`fall` and increments otherwise.
  - At `TIMEOUT`: `stuck`←1, lock counter and `locked` cleared, FSM forced to WAIT_RISE.
  - `stuck` clears on the next `rise`.
- **Simultaneous events.** A `rise` coinciding with an `n_exp` change causes no publish; the FSM enters WAIT_RISE. `rst` overrides everything.

## Timing
- **Reset.** With `rst`=1 at an edge:
  - `period`, `high_len`, `meas_valid`, `duty_ok`, `match`, `locked` and `stuck` are 0;
  - `s1`/`s2` and all counters are 0; FSM is in WAIT_RISE.
- **Reset mid-measurement** behaves identically and restarts cleanly. The first `rise` after reset only arms the FSM; the first `meas_valid` follows the second rising edge.
- **Latency.** `div_clk` is sampled into `s1` at edge k. `meas_valid`, `period` and related outputs are visible after edge k+1. `locked` updates in the same cycle as the `meas_valid` that completes the run.
- **Outputs.** `period`, `high_len`, `duty_ok` and `match` hold their values between pulses.
- **Odd divide ratios.** Negedge-generated halves resolve to ⌈n/2⌉ and ⌊n/2⌋ cycles; period is exact.

## Test plan
- **Reset hold.** Hold `rst`=1 for 5 cycles with `div_clk` toggling. Required: all outputs 0, no `meas_valid`.
- **Even ratio.** `div_clk` at 3 high/3 low, `n_exp`=6. Required:
  - `meas_valid` every 6 cycles with `period`=6, `high_len`=3, `duty_ok`=1, `match`=1;
  - `locked`=1 with the 3rd pulse.
- **Odd ratio.** `div_clk` at 6 high/5 low, `n_exp`=11. Required: `period`=11, `high_len`=6, `duty_ok`=1, `locked` after 3 periods.
- **n_exp change.** While locked at 6, set `n_exp`=11. Required:
  - `locked`=0 next edge, no pulse for the interrupted period;
  - then `period`=6, `match`=0, `locked` stays 0;
  - on switching the divider to 11, lock returns after 3 periods.
- **Stall and duty fault.**
  - With `TIMEOUT`=64, hold `div_clk`=0 for 64 cycles. Required: `stuck`=1, `locked`=0; `stuck`=0 after the next rise.
  - With 2 high/4 low and `n_exp`=6. Required: `period`=6, `duty_ok`=0, `match`=1.
- **Reset mid-LOW.** Assert `rst` for 1 cycle in state LOW. Required: outputs clear next edge, and the first `meas_valid` comes only after two further rising edges.
